// File: rtl/id_ex_stage_if.sv
// Bundle between the ID side (decoder, register file, hazard consumers) and the
// ID/EX register. The master drives id_* and flush; the slave returns ex_* and stall.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  flush;

  logic                  id_valid;
  logic                  id_RegDst;
  logic                  id_BranchEQ;
  logic                  id_BranchNE;
  logic                  id_MemRead;
  logic                  id_MemtoReg;
  logic                  id_MemWrite;
  logic                  id_ALUSrc;
  logic                  id_RegWrite;
  logic [2:0]            id_ALUOp;
  logic [DATA_WIDTH-1:0] id_rs_data;
  logic [DATA_WIDTH-1:0] id_rt_data;
  logic [DATA_WIDTH-1:0] id_imm_ext;
  logic [DATA_WIDTH-1:0] id_pc_plus4;
  logic [4:0]            id_rs;
  logic [4:0]            id_rt;
  logic [4:0]            id_rd;
  logic [4:0]            id_shamt;

  logic                  ex_valid;
  logic                  ex_RegDst;
  logic                  ex_BranchEQ;
  logic                  ex_BranchNE;
  logic                  ex_MemRead;
  logic                  ex_MemtoReg;
  logic                  ex_MemWrite;
  logic                  ex_ALUSrc;
  logic                  ex_RegWrite;
  logic [2:0]            ex_ALUOp;
  logic [DATA_WIDTH-1:0] ex_rs_data;
  logic [DATA_WIDTH-1:0] ex_rt_data;
  logic [DATA_WIDTH-1:0] ex_imm_ext;
  logic [DATA_WIDTH-1:0] ex_pc_plus4;
  logic [4:0]            ex_rs;
  logic [4:0]            ex_rt;
  logic [4:0]            ex_rd;
  logic [4:0]            ex_shamt;

  logic                  stall;
  logic [CNT_WIDTH-1:0]  stall_count;

  // Handshake: none. The register advances every edge; stall is an
  // advisory to PC and IF/ID, sampled on the same edge that loads EX.
  modport master (
    output flush, id_valid, id_RegDst, id_BranchEQ, id_BranchNE, id_MemRead,
           id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite, id_ALUOp,
           id_rs_data, id_rt_data, id_imm_ext, id_pc_plus4,
           id_rs, id_rt, id_rd, id_shamt,
    input  ex_valid, ex_RegDst, ex_BranchEQ, ex_BranchNE, ex_MemRead,
           ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_ALUOp,
           ex_rs_data, ex_rt_data, ex_imm_ext, ex_pc_plus4,
           ex_rs, ex_rt, ex_rd, ex_shamt,
           stall, stall_count
  );

  modport slave (
    input  flush, id_valid, id_RegDst, id_BranchEQ, id_BranchNE, id_MemRead,
           id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite, id_ALUOp,
           id_rs_data, id_rt_data, id_imm_ext, id_pc_plus4,
           id_rs, id_rt, id_rd, id_shamt,
    output ex_valid, ex_RegDst, ex_BranchEQ, ex_BranchNE, ex_MemRead,
           ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_ALUOp,
           ex_rs_data, ex_rt_data, ex_imm_ext, ex_pc_plus4,
           ex_rs, ex_rt, ex_rd, ex_shamt,
           stall, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection on
// hazard or branch flush, and a saturating stall-cycle counter.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic                 hazard;
  logic                 bubble;
  logic                 stallInt;
  logic [CNT_WIDTH-1:0] stallCount;

  // A load in EX whose destination is read by the ID instruction cannot
  // forward in time; $zero is never a real dependency.
  always_comb begin
    hazard = bus.ex_valid & bus.ex_MemRead & (bus.ex_rt != 5'd0) & bus.id_valid &
             ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));
    stallInt = hazard & ~bus.flush;
    bubble   = bus.flush | hazard;
  end

  assign bus.stall       = stallInt;
  assign bus.stall_count = stallCount;

  // Control word: zeroed on a bubble so the EX slot has no side effects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_RegDst   <= 1'b0;
      bus.ex_BranchEQ <= 1'b0;
      bus.ex_BranchNE <= 1'b0;
      bus.ex_MemRead  <= 1'b0;
      bus.ex_MemtoReg <= 1'b0;
      bus.ex_MemWrite <= 1'b0;
      bus.ex_ALUSrc   <= 1'b0;
      bus.ex_RegWrite <= 1'b0;
      bus.ex_ALUOp    <= 3'b000;
    end else if (bubble) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_RegDst   <= 1'b0;
      bus.ex_BranchEQ <= 1'b0;
      bus.ex_BranchNE <= 1'b0;
      bus.ex_MemRead  <= 1'b0;
      bus.ex_MemtoReg <= 1'b0;
      bus.ex_MemWrite <= 1'b0;
      bus.ex_ALUSrc   <= 1'b0;
      bus.ex_RegWrite <= 1'b0;
      bus.ex_ALUOp    <= 3'b000;
    end else begin
      bus.ex_valid    <= bus.id_valid;
      bus.ex_RegDst   <= bus.id_RegDst;
      bus.ex_BranchEQ <= bus.id_BranchEQ;
      bus.ex_BranchNE <= bus.id_BranchNE;
      bus.ex_MemRead  <= bus.id_MemRead;
      bus.ex_MemtoReg <= bus.id_MemtoReg;
      bus.ex_MemWrite <= bus.id_MemWrite;
      bus.ex_ALUSrc   <= bus.id_ALUSrc;
      bus.ex_RegWrite <= bus.id_RegWrite;
      bus.ex_ALUOp    <= bus.id_ALUOp;
    end
  end

  // Data and index fields load every edge; they are don't-care under a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ex_rs_data  <= '0;
      bus.ex_rt_data  <= '0;
      bus.ex_imm_ext  <= '0;
      bus.ex_pc_plus4 <= '0;
      bus.ex_rs       <= 5'd0;
      bus.ex_rt       <= 5'd0;
      bus.ex_rd       <= 5'd0;
      bus.ex_shamt    <= 5'd0;
    end else begin
      bus.ex_rs_data  <= bus.id_rs_data;
      bus.ex_rt_data  <= bus.id_rt_data;
      bus.ex_imm_ext  <= bus.id_imm_ext;
      bus.ex_pc_plus4 <= bus.id_pc_plus4;
      bus.ex_rs       <= bus.id_rs;
      bus.ex_rt       <= bus.id_rt;
      bus.ex_rd       <= bus.id_rd;
      bus.ex_shamt    <= bus.id_shamt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCount <= '0;
    end else if (stallInt && (stallCount != CntMax)) begin
      stallCount <= stallCount + 1'b1;
    end
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the pipelined MIPS datapath, placed directly downstream of the opcode control decoder and register file. Each cycle it captures the decoded control word and the operand, immediate, PC and register-index fields, and presents them to the execute stage. It also owns load-use hazard detection: it stalls PC and IF/ID and injects a bubble. Branch-taken flushes insert a bubble too, and a saturating counter records stall cycles.

## Interface
- DATA_WIDTH, 32, width of operand, immediate and PC fields
- CNT_WIDTH, 16, width of the stall-cycle counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  branch taken in EX; the current ID instruction is squashed
- id_valid  in  1  ID holds a real instruction
- id_RegDst, id_BranchEQ, id_BranchNE, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite  in  1 each  decoded control bits
- id_ALUOp  in  3  decoded ALU operation class
- id_rs_data, id_rt_data  in  DATA_WIDTH  register-file read data
- id_imm_ext  in  DATA_WIDTH  sign-extended immediate
- id_pc_plus4  in  DATA_WIDTH  PC+4 of the ID instruction
- id_rs, id_rt, id_rd, id_shamt  in  5 each  instruction fields
- ex_* (same names with the ex_ prefix)  out  same widths  registered copies of every id_* input above, including ex_valid
- stall  out  1  hold PC and IF/ID this cycle
- stall_count  out  CNT_WIDTH  saturating count of stall cycles

## Operation
- hazard = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- stall = hazard & ~flush. This is combinational from registered ex_* state and the id_* inputs.
- Bubble condition: flush | hazard.
- On the clock edge with bubble:
  - ex_valid <= 0.
  - All eight control bits <= 0 and ex_ALUOp <= 3'b000.
  - Data and index fields still load from id_* and are don't-care for EX, but the bench checks that they are captured.
- On the clock edge without bubble: every ex_* loads the matching id_* and ex_valid <= id_valid.
- If id_valid = 0, the control bits still load as presented. The decoder's default decode is all zeros, so an invalid slot carries no side effects.
- Priority: flush over hazard. When both are asserted, the register loads a bubble, stall = 0, and the counter does not increment.
- Counter: stall_count increments by 1 on each edge where stall = 1. It saturates at 2^CNT_WIDTH-1 and does not wrap.
- A single load-use pair produces exactly one stall cycle. The next edge puts a bubble (ex_valid = 0) in EX, which clears the hazard.
- An $zero destination (ex_rt = 0) never stalls.

## Timing
- Latency: 1 cycle from id_* to ex_*.
- stall is valid in the same cycle as the id_* inputs. PC and IF/ID sample it on the same rising edge.
- Reset (reset = 0, asynchronous):
  - All ex_* outputs go to 0 immediately, including ex_valid.
  - stall_count goes to 0.
  - stall reads 0 because ex_valid = 0.
- Reset deasserted mid-operation: the first edge after release loads normally. No pending stall survives reset.
- Back-to-back loads where each depends on the previous one: each load-use pair stalls one cycle independently.
- flush held for several cycles: a bubble is loaded on every flushed edge.

## Test plan
- Reset: assert reset = 0 mid-stream with random inputs -> all ex_* = 0, ex_valid = 0, stall = 0, stall_count = 0 with no clock edge needed.
- Pass-through: id_valid = 1, ADDI controls (ALUSrc = 1, RegWrite = 1, ALUOp = 3'b110), id_rs_data = 32'h1234_5678 -> next edge shows identical ex_* and ex_valid = 1; stall never asserts.
- Load-use:
  - Stimulus: LW with id_rt = 8, MemRead = 1, then an ID instruction with id_rs = 8.
  - Required: stall = 1 for exactly one cycle, ex_valid = 0 with all controls 0 after that edge, and stall_count = 1.
  - With the ID inputs held, the dependent instruction enters EX on the following edge.
- $zero and no-match: LW with id_rt = 0 followed by an instruction with id_rs = 0 -> stall = 0. LW with id_rt = 9 followed by rs = 8, rt = 10 -> stall = 0.
- Flush priority: load-use condition present and flush = 1 in the same cycle -> stall = 0, a bubble is loaded, stall_count unchanged.
- Saturation: with CNT_WIDTH = 4, force 20 load-use stalls -> stall_count reaches 15 and stays at 15.
